cpu_controller: RTL and testbench

Multi-cycle control sequencer that drives the 4x10-bit register file and the shared 10-bit data bus of the small CPU. It starts an instruction on a rising edge of the external execute input and decodes the latched 10-bit instruction. It sequences the read enables and addresses, the write enable and address, external-data drive, and the ALU operand/result strobes over 2-4 cycles. It signals DONE when the instruction is finished. The register file writes on the falling edge of CLKb. This block updates on the rising edge, so every control output is stable half a cycle before the write.

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/cpu_controller_if.sv | 41 ++++
 rtl/cpu_controller_instr_decode.sv | 29 ++
 rtl/cpu_controller.sv | 127 ++++++++++++
 tb/tb_cpu_controller.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the CPU control sequencer.
//   state_t  : sequencer states T0..T3 (T0 is idle/fetch)
//   opcode_t : instruction opcodes (any opcode with the MSB set is a NOP)
//   Field-slice positions of the 10-bit instruction word.
package cpu_pkg;

    localparam int RA_W    = 2;   // register address width (4 registers)
    localparam int OP_W    = 4;   // opcode / ALU function width
    localparam int INSTR_W = 10;

    localparam int OPC_MSB = 9;   // [9:6] opcode
    localparam int RX_LSB  = 4;   // [5:4] Rx
    localparam int RY_LSB  = 2;   // [3:2] Ry

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    typedef enum logic [OP_W-1:0] {
        OP_LOAD = 4'b0000,
        OP_COPY = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SUB  = 4'b0011,
        OP_INV  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_OR   = 4'b0110,
        OP_XOR  = 4'b0111,
        OP_NOP  = 4'b1000
    } opcode_t;

endpackage

// File: rtl/cpu_controller_if.sv
// cpu_controller_if: control/bus signal bundle between the sequencer and the
// datapath (register file, instruction register, ALU, bus drivers).
//   master : the sequencer side (drives strobes, reads PEXT/INSTR/DBG_SEL)
//   slave  : the datapath/environment side
// Handshake: PEXT is a level request; an instruction starts on its 0->1 edge
// while idle, and DONE is high for exactly the final cycle of that
// instruction. A new start needs PEXT to fall and rise again after DONE.
interface cpu_controller_if;
    import cpu_pkg::*;

    logic                 PEXT;
    logic [INSTR_W-1:0]   INSTR;
    logic [RA_W-1:0]      DBG_SEL;
    logic                 IR_EN;
    logic                 ENW;
    logic [RA_W-1:0]      WRA;
    logic                 ENR0;
    logic [RA_W-1:0]      RDA0;
    logic                 ENR1;
    logic [RA_W-1:0]      RDA1;
    logic                 EXT_EN;
    logic                 A_EN;
    logic [OP_W-1:0]      ALU_OP;
    logic                 G_EN;
    logic                 G_OUT;
    logic                 DONE;
    logic [1:0]           STATE;

    modport master (
        input  PEXT, INSTR, DBG_SEL,
        output IR_EN, ENW, WRA, ENR0, RDA0, ENR1, RDA1,
               EXT_EN, A_EN, ALU_OP, G_EN, G_OUT, DONE, STATE
    );

    modport slave (
        output PEXT, INSTR, DBG_SEL,
        input  IR_EN, ENW, WRA, ENR0, RDA0, ENR1, RDA1,
               EXT_EN, A_EN, ALU_OP, G_EN, G_OUT, DONE, STATE
    );

endinterface

// File: rtl/cpu_controller_instr_decode.sv
// instr_decode: purely combinational split of the instruction word.
//   instr  in  10  instruction-register output
//   opcode out 4   [9:6]
//   rx     out 2   [5:4]
//   ry     out 2   [3:2]
//   is_alu out 1   opcode is one of ADD..XOR
//   is_nop out 1   opcode MSB set (1000-1111)
module instr_decode
    import cpu_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output logic [OP_W-1:0]    opcode,
    output logic [RA_W-1:0]    rx,
    output logic [RA_W-1:0]    ry,
    output logic               is_alu,
    output logic               is_nop
);

    // Bits [1:0] carry no meaning for the controller.
    logic unused_low_bits;
    assign unused_low_bits = ^instr[1:0];

    assign opcode = instr[OPC_MSB -: OP_W];
    assign rx     = instr[RX_LSB +: RA_W];
    assign ry     = instr[RY_LSB +: RA_W];
    assign is_nop = opcode[OP_W-1];
    assign is_alu = !is_nop && (opcode >= OP_ADD);

endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: multi-cycle control sequencer for the small CPU.
//   CLKb  in  system clock, state updates on posedge (register file writes
//             on the falling edge, so all strobes settle half a cycle early)
//   RST   in  synchronous active-high reset
//   bus   master modport of cpu_controller_if (request, instruction, debug
//             select in; register-file, bus-driver and ALU strobes out)
// Instruction timing from the start cycle: LOAD/COPY/NOP finish in T1,
// ALU ops go T1 (operand A) -> T2 (operand B, ALU) -> T3 (write back).
module cpu_controller
    import cpu_pkg::*;
(
    input  logic              CLKb,
    input  logic              RST,
    cpu_controller_if.master  bus
);

    state_t state, state_next;
    logic   pext_q;
    logic   start;

    logic [OP_W-1:0] opcode;
    logic [RA_W-1:0] rx, ry;
    logic            is_alu, is_nop;

    logic            ir_en, enw, enr0, ext_en, a_en, g_en, g_out, done;
    logic [RA_W-1:0] wra, rda0;
    logic [OP_W-1:0] alu_op;

    instr_decode u_decode (
        .instr  (bus.INSTR),
        .opcode (opcode),
        .rx     (rx),
        .ry     (ry),
        .is_alu (is_alu),
        .is_nop (is_nop)
    );

    // pext_q resets to 1 so a request already high at reset release is not
    // mistaken for a fresh edge.
    always_ff @(posedge CLKb) begin
        if (RST) begin
            state  <= T0;
            pext_q <= 1'b1;
        end else begin
            state  <= state_next;
            pext_q <= bus.PEXT;
        end
    end

    assign start = bus.PEXT & ~pext_q;

    always_comb begin
        state_next = state;
        ir_en      = 1'b0;
        enw        = 1'b0;
        wra        = '0;
        enr0       = 1'b0;
        rda0       = '0;
        ext_en     = 1'b0;
        a_en       = 1'b0;
        alu_op     = '0;
        g_en       = 1'b0;
        g_out      = 1'b0;
        done       = 1'b0;
        case (state)
            T0: begin
                // Edges seen outside T0 are dropped, never queued.
                ir_en = start;
                if (start) state_next = T1;
            end
            T1: begin
                state_next = T0;
                if (is_nop) begin
                    done = 1'b1;
                end else if (opcode == OP_LOAD) begin
                    ext_en = 1'b1;
                    enw    = 1'b1;
                    wra    = rx;
                    done   = 1'b1;
                end else if (opcode == OP_COPY) begin
                    enr0 = 1'b1;
                    rda0 = ry;
                    enw  = 1'b1;
                    wra  = rx;
                    done = 1'b1;
                end else if (is_alu) begin
                    enr0       = 1'b1;
                    rda0       = rx;
                    a_en       = 1'b1;
                    state_next = T2;
                end
            end
            T2: begin
                enr0       = 1'b1;
                rda0       = ry;
                alu_op     = opcode;
                g_en       = 1'b1;
                state_next = T3;
            end
            T3: begin
                g_out      = 1'b1;
                enw        = 1'b1;
                wra        = rx;
                done       = 1'b1;
                state_next = T0;
            end
        endcase
    end

    // Reset forces every strobe low in the same cycle, so an instruction
    // aborted by reset never writes and never reports DONE.
    assign bus.IR_EN  = RST ? 1'b0 : ir_en;
    assign bus.ENW    = RST ? 1'b0 : enw;
    assign bus.WRA    = RST ? '0   : wra;
    assign bus.ENR0   = RST ? 1'b0 : enr0;
    assign bus.RDA0   = RST ? '0   : rda0;
    assign bus.EXT_EN = RST ? 1'b0 : ext_en;
    assign bus.A_EN   = RST ? 1'b0 : a_en;
    assign bus.ALU_OP = RST ? '0   : alu_op;
    assign bus.G_EN   = RST ? 1'b0 : g_en;
    assign bus.G_OUT  = RST ? 1'b0 : g_out;
    assign bus.DONE   = RST ? 1'b0 : done;
    assign bus.STATE  = RST ? 2'b00 : state;
    assign bus.ENR1   = 1'b1;
    assign bus.RDA1   = bus.DBG_SEL;

endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: scoreboard bench for cpu_controller. Each driven cycle
// pushes the full expected output vector; the negedge monitor pops and
// compares it against the DUT outputs.
module tb_cpu_controller;
    import cpu_pkg::*;

    localparam int VW = 21;

    logic clk;
    logic rst;

    cpu_controller_if bus_if ();

    cpu_controller dut (
        .CLKb (clk),
        .RST  (rst),
        .bus  (bus_if)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard ----------------
    logic [VW-1:0] exp_q[$];
    string         tag_q[$];
    int            n_checks = 0;
    int            n_errors = 0;
    logic          last_pext = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {IR_EN, ENW, WRA, ENR0, RDA0, ENR1, RDA1, EXT_EN, A_EN, ALU_OP, G_EN, G_OUT, DONE, STATE}
    function automatic logic [VW-1:0] act_vec();
        return {bus_if.IR_EN, bus_if.ENW, bus_if.WRA, bus_if.ENR0, bus_if.RDA0,
                bus_if.ENR1, bus_if.RDA1, bus_if.EXT_EN, bus_if.A_EN, bus_if.ALU_OP,
                bus_if.G_EN, bus_if.G_OUT, bus_if.DONE, bus_if.STATE};
    endfunction

    // Expected vector with ENR1=1; RDA1 is filled in by drive_cycle.
    function automatic logic [VW-1:0] mk(
        input logic ir, input logic enw, input logic [1:0] wra,
        input logic enr0, input logic [1:0] rda0,
        input logic ext, input logic aen, input logic [3:0] op,
        input logic gen, input logic gout, input logic done, input logic [1:0] st);
        return {ir, enw, wra, enr0, rda0, 1'b1, 2'b00, ext, aen, op, gen, gout, done, st};
    endfunction

    function automatic logic [VW-1:0] idle_vec();
        return mk(0, 0, 2'd0, 0, 2'd0, 0, 0, 4'd0, 0, 0, 0, 2'd0);
    endfunction

    always @(negedge clk) begin
        logic [VW-1:0] e;
        string         t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, 32'(act_vec()), 32'(e));
            check({t, "_bus_excl"},
                  32'($onehot0({bus_if.EXT_EN, bus_if.ENR0, bus_if.G_OUT})), 32'd1);
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a posedge; applies inputs for one cycle.
    task automatic drive_cycle(input logic r, input logic pext, input logic [9:0] instr,
                               input logic [VW-1:0] expv, input string tag);
        logic [1:0]    dbg;
        logic [VW-1:0] e;
        dbg            = 2'($urandom_range(0, 3));
        rst            = r;
        bus_if.PEXT    = pext;
        bus_if.INSTR   = instr;
        bus_if.DBG_SEL = dbg;
        e              = expv;
        e[12:11]       = dbg;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        last_pext = r ? 1'b1 : pext;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_cycles(input int n, input logic pext);
        for (int i = 0; i < n; i++)
            drive_cycle(1'b1, pext, 10'($urandom), idle_vec(), "reset");
    endtask

    task automatic idle(input int n, input logic pext, input string tag);
        for (int i = 0; i < n; i++)
            drive_cycle(1'b0, pext, 10'($urandom), idle_vec(), tag);
    endtask

    // mode 0: PEXT held high for the whole instruction.
    // mode 1: PEXT low in T1 and high again from T2 (a late edge to ignore).
    // abort_at: cycle index (0 = start cycle) at which RST is raised, -1 = none.
    task automatic exec(input logic [9:0] instr, input int mode, input int abort_at,
                        input string tag);
        logic [VW-1:0] seq[$];
        logic [3:0]    opc;
        logic [1:0]    rx, ry;
        logic          p;
        opc = instr[9:6];
        rx  = instr[5:4];
        ry  = instr[3:2];
        if (last_pext) idle(1, 1'b0, {tag, "_pre"});
        seq.push_back(mk(1, 0, 2'd0, 0, 2'd0, 0, 0, 4'd0, 0, 0, 0, 2'd0));
        if (opc[3]) begin
            seq.push_back(mk(0, 0, 2'd0, 0, 2'd0, 0, 0, 4'd0, 0, 0, 1, 2'd1));
        end else if (opc == 4'b0000) begin
            seq.push_back(mk(0, 1, rx, 0, 2'd0, 1, 0, 4'd0, 0, 0, 1, 2'd1));
        end else if (opc == 4'b0001) begin
            seq.push_back(mk(0, 1, rx, 1, ry, 0, 0, 4'd0, 0, 0, 1, 2'd1));
        end else begin
            seq.push_back(mk(0, 0, 2'd0, 1, rx, 0, 1, 4'd0, 0, 0, 0, 2'd1));
            seq.push_back(mk(0, 0, 2'd0, 1, ry, 0, 0, opc,  1, 0, 0, 2'd2));
            seq.push_back(mk(0, 1, rx,   0, 2'd0, 0, 0, 4'd0, 0, 1, 1, 2'd3));
        end
        for (int i = 0; i < seq.size(); i++) begin
            p = (mode == 1 && i == 1) ? 1'b0 : 1'b1;
            if (i == abort_at) begin
                drive_cycle(1'b1, p, instr, idle_vec(), {tag, "_abort"});
                return;
            end
            drive_cycle(1'b0, p, instr, seq[i], $sformatf("%s_c%0d", tag, i));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [9:0] ri;
        rst            = 1'b1;
        bus_if.PEXT    = 1'b1;
        bus_if.INSTR   = '0;
        bus_if.DBG_SEL = 2'b10;
        @(posedge clk);
        #1;

        reset_cycles(2, 1'b1);
        idle(3, 1'b1, "post_rst_idle");

        exec(10'b0000_11_00_00, 0, -1, "load");
        idle(2, 1'b0, "gap");
        exec(10'b0010_01_10_00, 0, -1, "add");

        // Request held high: one instruction, then silence.
        exec(10'b0111_10_01_00, 0, -1, "xor_held");
        idle(6, 1'b1, "held_idle");

        // Second rising edge during T2 must be ignored.
        exec(10'b0101_11_10_00, 1, -1, "and_late_edge");
        idle(3, 1'b1, "late_edge_idle");

        // Reset in T2 of a SUB, then a COPY.
        exec(10'b0011_10_01_00, 0, 2, "sub_abort");
        idle(1, 1'b1, "abort_idle");
        exec(10'b0001_00_11_00, 0, -1, "copy");

        exec(10'b1011_01_10_00, 0, -1, "nop");
        idle(1, 1'b0, "gap");

        for (int n = 0; n < 40; n++) begin
            ri = 10'($urandom);
            exec(ri, int'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1,
                 $sformatf("rnd%0d", n));
            if ($urandom_range(0, 1) == 1)
                idle(int'($urandom_range(1, 3)), 1'b0, "rnd_gap");
        end
        idle(2, 1'b0, "tail");

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
